// File: rtl/tx_tlp_assembler_if.sv
// Bundle of the three TX FIFO read ports and the outgoing TLP beat stream.
// master: the assembler side; slave: FIFOs plus downstream framing stage.
interface tx_tlp_assembler_if #(
    parameter int DATA_WIDTH = 256,
    parameter int HDR_WIDTH  = 128
);
    logic                  aw_empty_i;
    logic [HDR_WIDTH-1:0]  aw_rdata_i;
    logic                  aw_rden_o;
    logic                  ar_empty_i;
    logic [HDR_WIDTH-1:0]  ar_rdata_i;
    logic                  ar_rden_o;
    logic                  pw_empty_i;
    logic [DATA_WIDTH-1:0] pw_rdata_i;
    logic                  pw_last_i;
    logic                  pw_rden_o;
    logic [DATA_WIDTH-1:0] tlp_data_o;
    logic                  tlp_valid_o;
    logic                  tlp_sop_o;
    logic                  tlp_eop_o;
    logic                  tlp_ready_i;

    modport master (
        input  aw_empty_i, aw_rdata_i, ar_empty_i, ar_rdata_i,
        input  pw_empty_i, pw_rdata_i, pw_last_i, tlp_ready_i,
        output aw_rden_o, ar_rden_o, pw_rden_o,
        output tlp_data_o, tlp_valid_o, tlp_sop_o, tlp_eop_o
    );

    modport slave (
        output aw_empty_i, aw_rdata_i, ar_empty_i, ar_rdata_i,
        output pw_empty_i, pw_rdata_i, pw_last_i, tlp_ready_i,
        input  aw_rden_o, ar_rden_o, pw_rden_o,
        input  tlp_data_o, tlp_valid_o, tlp_sop_o, tlp_eop_o
    );
endinterface

// File: rtl/tx_tlp_assembler.sv
// TX TLP assembler: round-robin between MWr (AW header + payload) and MRd
// (AR header) TLPs, shifting write payload up by one 128-bit header slot.
// HDR_WIDTH must be DATA_WIDTH/2; the realignment relies on it.
module tx_tlp_assembler #(
    parameter int DATA_WIDTH = 256,
    parameter int HDR_WIDTH  = 128
) (
    input  logic               clk,
    input  logic               rst,
    tx_tlp_assembler_if.master bus
);
    localparam int HW = HDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WR_BODY, WR_TAIL} state_t;

    state_t                r_state;
    logic [HW-1:0]         r_carry;     // upper payload half waiting for the next beat
    logic                  r_last_wr;   // last grant was a write (0 = prefer write)
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_sop;
    logic                  r_eop;

    logic w_slot_free;
    logic w_wr_ok;
    logic w_rd_ok;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_body_pop;

    assign w_slot_free = !r_valid || bus.tlp_ready_i;
    assign w_wr_ok     = !bus.aw_empty_i && !bus.pw_empty_i;
    assign w_rd_ok     = !bus.ar_empty_i;
    // Write wins unless a read is also eligible and the previous grant was a write.
    assign w_grant_wr  = (r_state == IDLE) && w_wr_ok && (!w_rd_ok || !r_last_wr);
    assign w_grant_rd  = (r_state == IDLE) && w_rd_ok && !w_grant_wr;
    assign w_body_pop  = (r_state == WR_BODY) && !bus.pw_empty_i;

    // Pops are combinational so the FIFO head advances in the same cycle the
    // beat is loaded; rst gating keeps them quiet during reset.
    assign bus.aw_rden_o = !rst && w_slot_free && w_grant_wr;
    assign bus.ar_rden_o = !rst && w_slot_free && w_grant_rd;
    assign bus.pw_rden_o = !rst && w_slot_free && (w_grant_wr || w_body_pop);

    assign bus.tlp_data_o  = r_data;
    assign bus.tlp_valid_o = r_valid;
    assign bus.tlp_sop_o   = r_sop;
    assign bus.tlp_eop_o   = r_eop;

    // Packet FSM and output beat register; advances only when the slot is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_carry   <= '0;
            r_last_wr <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
        end else if (w_slot_free) begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_wr) begin
                        r_data    <= {bus.pw_rdata_i[HW-1:0], bus.aw_rdata_i};
                        r_valid   <= 1'b1;
                        r_sop     <= 1'b1;
                        r_carry   <= bus.pw_rdata_i[DATA_WIDTH-1:HW];
                        r_last_wr <= 1'b1;
                        r_state   <= bus.pw_last_i ? WR_TAIL : WR_BODY;
                    end else if (w_grant_rd) begin
                        r_data    <= {{HW{1'b0}}, bus.ar_rdata_i};
                        r_valid   <= 1'b1;
                        r_sop     <= 1'b1;
                        r_eop     <= 1'b1;
                        r_last_wr <= 1'b0;
                    end
                end
                WR_BODY: begin
                    // Payload underflow just leaves a gap; the packet stays open.
                    if (w_body_pop) begin
                        r_data  <= {bus.pw_rdata_i[HW-1:0], r_carry};
                        r_valid <= 1'b1;
                        r_carry <= bus.pw_rdata_i[DATA_WIDTH-1:HW];
                        if (bus.pw_last_i) r_state <= WR_TAIL;
                    end
                end
                WR_TAIL: begin
                    r_data  <= {{HW{1'b0}}, r_carry};
                    r_valid <= 1'b1;
                    r_eop   <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
